// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage radix-2 restoring divider.
// State encoding matches the 2-bit DivFree/DivByZero/DivOn/DivEnd codes used by the EX stage.
package ex_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic [63:0] ZERO_DWORD    = 64'd0;

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step: shift {rem, quot} left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module ex_div_step
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // The shifted remainder stays below 2*divisor, so one extra bit covers the borrow.
  assign shifted   = {rem, quot[WIDTH-1]};
  assign trial     = shifted - {1'b0, divisor};
  assign borrow    = trial[WIDTH];
  assign rem_next  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU unit for the EX stage: result_o = {remainder, quotient}.
// Optional macro DIV_EARLY_TERM_EN finishes at once when |dividend| < |divisor|.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t         state, next_state;
  logic [WIDTH-1:0]   rem_q, quot_q, divisor_q;
  logic [CNT_W-1:0]   cnt;
  logic               neg1_q, neg2_q;
  logic [2*WIDTH-1:0] result_q;

  logic               accept, div_zero, last_step, early_term;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   rem_next, quot_next, fixed_rem, fixed_quot;

  assign accept    = (start_i == DIV_START) && !annul_i;
  assign div_zero  = (opdata2_i == '0);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign neg1      = signed_div_i && opdata1_i[WIDTH-1];
  assign neg2      = signed_div_i && opdata2_i[WIDTH-1];
  assign mag1      = neg1 ? (WIDTH'(0) - opdata1_i) : opdata1_i;
  assign mag2      = neg2 ? (WIDTH'(0) - opdata2_i) : opdata2_i;

`ifdef DIV_EARLY_TERM_EN
  assign early_term = !div_zero && (mag1 < mag2);
`else
  assign early_term = 1'b0;
`endif

  ex_div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Quotient is negative when the signs differ; the remainder follows the dividend.
  assign fixed_quot = (neg1_q ^ neg2_q) ? (WIDTH'(0) - quot_next) : quot_next;
  assign fixed_rem  = neg1_q ? (WIDTH'(0) - rem_next) : rem_next;

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_FREE: begin
        if (accept) begin
          if (div_zero)        next_state = DIV_BY_ZERO;
          else if (early_term) next_state = DIV_END;
          else                 next_state = DIV_ON;
        end
      end
      DIV_BY_ZERO: next_state = DIV_END;
      DIV_ON: begin
        if (annul_i)        next_state = DIV_FREE;
        else if (last_step) next_state = DIV_END;
      end
      DIV_END: begin
        if ((start_i == DIV_STOP) || annul_i) next_state = DIV_FREE;
      end
      default: next_state = DIV_FREE;
    endcase
  end

  always_comb begin
    ready_o  = DIV_RESULT_NOT_READY;
    result_o = result_q;
    if (state == DIV_END) ready_o = DIV_RESULT_READY;
  end

  // Operand magnitudes are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt       <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= ZERO_DWORD[2*WIDTH-1:0];
    end else begin
      case (state)
        DIV_FREE: begin
          if (accept) begin
            rem_q     <= '0;
            quot_q    <= mag1;
            divisor_q <= mag2;
            neg1_q    <= neg1;
            neg2_q    <= neg2;
            cnt       <= '0;
            if (early_term) result_q <= {opdata1_i, WIDTH'(0)};
          end
        end
        DIV_BY_ZERO: result_q <= '0;
        DIV_ON: begin
          if (!annul_i) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) result_q <= {fixed_rem, fixed_quot};
          end
        end
        DIV_END: begin
          if ((start_i == DIV_STOP) || annul_i) result_q <= '0;
        end
        default: result_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, results, sign handling, divide-by-zero,
// annul and mid-operation reset. Expected early-termination latency follows DIV_EARLY_TERM_EN.
module tb_ex_div;

`ifdef DIV_EARLY_TERM_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests_run = 0;
  int tests_failed = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic start, input logic annul);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = start;
    annul_i      = annul;
  endtask

  // Issue one divide, measure edges until ready, check the held result and the release.
  task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int edges;
    edges = 0;
    applyStimulus(sgn, a, b, 1'b1, 1'b0);
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        opdata1_i = ~a;
        opdata2_i = b ^ 32'h5;
      end
    end while (!ready_o && edges < 100);
    checkOutput({tag, " latency"}, 64'(edges), 64'(exp_lat));
    checkOutput({tag, " result"}, result_o, exp_res);
    @(posedge clk); #1;
    checkOutput({tag, " held ready"}, 64'(ready_o), 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, " drop ready"}, 64'(ready_o), 64'd0);
    checkOutput({tag, " drop result"}, result_o, 64'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runDivide("divu 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    runDivide("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runDivide("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    runDivide("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
    runDivide("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF});
    runDivide("divu 5/0", 1'b0, 32'd5, 32'd0, 2, 64'd0);
    runDivide("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 64'd0);
    runDivide("divu 3/10", 1'b0, 32'd3, 32'd10, EARLY_LAT, {32'd3, 32'd0});
    runDivide("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, EARLY_LAT, {32'hFFFF_FFFD, 32'd0});

    // Annul at E10: must return to DIV_FREE and never raise ready
    seen = 1'b0;
    applyStimulus(1'b0, 32'd1000, 32'd7, 1'b1, 1'b0);
    repeat (10) begin @(posedge clk); #1; seen |= ready_o; end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1; seen |= ready_o;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    checkOutput("annul ready never", 64'(seen), 64'd0);
    checkOutput("annul result", result_o, 64'd0);

    // Reset at E5 of a second operation
    seen = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_FF00, 32'd3, 1'b1, 1'b0);
    repeat (5) begin @(posedge clk); #1; seen |= ready_o; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; seen |= ready_o;
    checkOutput("midrst result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready_o; end
    checkOutput("midrst ready never", 64'(seen), 64'd0);

    runDivide("divu 9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
